adc_spis_mc: RTL

//  Parametrised SPI slave receiving ADC frames from the PSoC5LP SPIM: {channel, sample}, MSB first, SPI mode 0.

---
 rtl/adc_spis_mc_pkg.sv | 21 ++
 rtl/adc_spis_mc_if.sv | 9 +
 rtl/adc_spis_mc_spi_pin_sync.sv | 35 +++
 rtl/adc_spis_mc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/adc_spis_mc_pkg.sv
// Shared types and helpers for the adc_spis_mc SPI slave.
// ADC_SPIS_MC_PARITY_EN adds a trailing even-parity bit to every frame.
package adc_spis_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} spis_state_t;

`ifdef ADC_SPIS_MC_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    // Frame width for the default geometry (4-bit channel, 12-bit sample)
    localparam int unsigned FRAME_W = 4 + 12 + PAR_W;

    // XOR reduction; zero for a vector holding an even number of ones
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/adc_spis_mc_if.sv
// SPI pin bundle between the board ADC link (master) and adc_spis_mc (slave).
interface adc_spis_mc_if;
    logic scs_n;
    logic sclk;
    logic sdat;

    modport master (output scs_n, output sclk, output sdat);
    modport slave  (input  scs_n, input  sclk, input  sdat);
endinterface

// File: rtl/adc_spis_mc_spi_pin_sync.sv
// Oversampling front end: 2-FF synchronisers on the three SPI pins plus an
// edge register producing single-cycle sclk_rise / cs_fall / cs_rise events.
// These flops are pure pipeline and simply track the pins, also during reset,
// so a chip select already low at reset release does not fake a cs_fall.
module spi_pin_sync (
    input  logic clk,
    input  logic i_scs_n,
    input  logic i_sclk,
    input  logic i_sdat,
    output logic o_sdat_s,
    output logic o_sclk_rise,
    output logic o_cs_fall,
    output logic o_cs_rise
);
    logic [1:0] r_cs_ff;
    logic [1:0] r_sclk_ff;
    logic [1:0] r_sdat_ff;
    logic       r_cs_q;
    logic       r_sclk_q;

    // Synchronise the pins and keep the previous synchronised level for edges
    always_ff @(posedge clk) begin
        r_cs_ff   <= {r_cs_ff[0], i_scs_n};
        r_sclk_ff <= {r_sclk_ff[0], i_sclk};
        r_sdat_ff <= {r_sdat_ff[0], i_sdat};
        r_cs_q    <= r_cs_ff[1];
        r_sclk_q  <= r_sclk_ff[1];
    end

    assign o_sdat_s    = r_sdat_ff[1];
    assign o_sclk_rise = r_sclk_ff[1] & ~r_sclk_q;
    assign o_cs_fall   = ~r_cs_ff[1] & r_cs_q;
    assign o_cs_rise   = r_cs_ff[1] & ~r_cs_q;

endmodule

// File: rtl/adc_spis_mc.sv
// SPI slave receiving {channel, sample} ADC frames (MSB first, mode 0) and
// writing them into a per-channel register bank. Pins are oversampled in clk.
// Optional: ADC_SPIS_MC_PARITY_EN appends and checks an even-parity bit.
module adc_spis_mc
    import adc_spis_pkg::*;
#(
    parameter int unsigned NUM_CH   = 16,
    parameter int unsigned CH_W     = 4,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    adc_spis_mc_if.slave                   spi,
    output logic [NUM_CH-1:0][DATA_W-1:0]  readings,
    output logic [NUM_CH-1:0]              valid,
    input  logic                           clear_valid,
    output logic                           upd_stb,
    output logic [CH_W-1:0]                upd_ch,
    output logic [ERRCNT_W-1:0]            frame_err_cnt
);
    localparam int unsigned FRM_W = CH_W + DATA_W + PAR_W;
    localparam int unsigned CNT_W = $clog2(FRM_W + 1);

    logic                          w_sdat_s;
    logic                          w_sclk_rise;
    logic                          w_cs_fall;
    logic                          w_cs_rise;

    spis_state_t                   r_state;
    spis_state_t                   w_state_d;
    logic [FRM_W-1:0]              r_shift;
    logic [FRM_W-1:0]              w_shift_d;
    logic [CNT_W-1:0]              r_bit_cnt;
    logic [CNT_W-1:0]              w_bit_cnt_d;

    logic [CH_W-1:0]               w_ch;
    logic [DATA_W-1:0]             w_data;
    logic                          w_par_ok;
    logic                          w_frame_ok;
    logic                          w_accept;
    logic                          w_reject;

    logic [NUM_CH-1:0][DATA_W-1:0] r_readings;
    logic [NUM_CH-1:0]             r_valid;
    logic [NUM_CH-1:0]             w_valid_d;
    logic                          r_upd_stb;
    logic [CH_W-1:0]               r_upd_ch;
    logic [ERRCNT_W-1:0]           r_err_cnt;

    spi_pin_sync u_pin_sync (
        .clk         (clk),
        .i_scs_n     (spi.scs_n),
        .i_sclk      (spi.sclk),
        .i_sdat      (spi.sdat),
        .o_sdat_s    (w_sdat_s),
        .o_sclk_rise (w_sclk_rise),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise)
    );

    // Frame FSM state, shift register and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
        end
    end

    // Next state: a sclk_rise coincident with cs_rise is still shifted in
    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_d   = SHIFT;
                    w_shift_d   = '0;
                    w_bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    w_shift_d = {r_shift[FRM_W-2:0], w_sdat_s};
                    // Saturate one past a full frame so overlong frames never wrap
                    if (r_bit_cnt != CNT_W'(FRM_W + 1)) begin
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                    end
                end
                if (w_cs_rise) begin
                    w_state_d = CHECK;
                end
            end
            CHECK: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign w_ch   = r_shift[FRM_W-1 -: CH_W];
    assign w_data = r_shift[PAR_W +: DATA_W];

`ifdef ADC_SPIS_MC_PARITY_EN
    // Even parity over {ch, data, parity bit} must reduce to zero
    assign w_par_ok = ~even_par(64'(r_shift));
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_frame_ok = (r_bit_cnt == CNT_W'(FRM_W)) && (32'(w_ch) < NUM_CH) && w_par_ok;
    assign w_accept   = (r_state == CHECK) && w_frame_ok;
    assign w_reject   = (r_state == CHECK) && !w_frame_ok;

    // Valid flags: clear_valid drops all bits, but a same-cycle write wins
    always_comb begin
        w_valid_d = clear_valid ? '0 : r_valid;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_accept && (w_ch == CH_W'(i))) begin
                w_valid_d[i] = 1'b1;
            end
        end
    end

    // Register bank, update strobe and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readings <= '0;
            r_valid    <= '0;
            r_upd_stb  <= 1'b0;
            r_upd_ch   <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_valid   <= w_valid_d;
            r_upd_stb <= w_accept;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_accept && (w_ch == CH_W'(i))) begin
                    r_readings[i] <= w_data;
                end
            end
            if (w_accept) begin
                r_upd_ch <= w_ch;
            end
            if (w_reject && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign readings      = r_readings;
    assign valid         = r_valid;
    assign upd_stb       = r_upd_stb;
    assign upd_ch        = r_upd_ch;
    assign frame_err_cnt = r_err_cnt;

endmodule
